draw_text_box: RTL
==================

Name: draw_text_box

Overview:
- Parametrised text-box overlay on the VGA timing stream: draws a COLS x ROWS grid of CHAR_W x CHAR_H glyph cells at (XPOS, YPOS) over the incoming rgb stream.
- Drives an external char-code RAM / font ROM chain (cell address plus glyph line), then re-aligns the returned glyph bits with a delayed copy of the timing signals.
- Adds an rgb passthrough, a transparent-background mode and a blinking cursor cell driven by a vsync-edge frame counter.
- Sits in the video pipeline after the board/mouse draw stages. Used for status lines and menus.

Parameters:
- XPOS, 490, left pixel column of the box
- YPOS, 600, top pixel line of the box
- COLS, 5, character cells per row (1..64)
- ROWS, 1, character rows (1..16)
- CHAR_W, 8, cell width in pixels; power of two, equals width of char_pixels
- CHAR_H, 16, cell height in lines; power of two
- ROM_LAT, 2, cycles from char_col/char_row/char_line to a valid char_pixels (1..4)
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)
- FG_COLOR, 12'h333, glyph colour
- BG_COLOR, 12'heee, cell background colour

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-low
- hcount_in, vcount_in  in  11 each  pixel position
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  upstream pixel colour
- enable  in  1  0 = whole block transparent
- transparent  in  1  1 = background pixels show rgb_in
- cursor_en  in  1  enable the blinking cursor cell
- cursor_col  in  clog2(COLS)  cursor column
- cursor_row  in  clog2(ROWS)  cursor row
- char_pixels  in  CHAR_W  glyph line bits; MSB = leftmost pixel
- char_col  out  clog2(COLS) (min 1)  cell column, combinational from hcount_in
- char_row  out  clog2(ROWS) (min 1)  cell row, combinational from vcount_in
- char_line  out  clog2(CHAR_H)  line within the cell
- hcount_out, vcount_out  out  11 each  delayed positions
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited colour

Behaviour:
- Reset: when rst==0 at a pclk edge, all registered outputs and the whole delay line are cleared to 0, frame_cnt=0, blink_phase=0, vsync_prev=0. Reset mid-frame takes effect on the next edge; the first valid output follows ROM_LAT+1 clean inputs.
- Box geometry:
  - in_box = XPOS <= hcount_in < XPOS+COLS*CHAR_W and YPOS <= vcount_in < YPOS+ROWS*CHAR_H.
  - Offsets: hrel = hcount_in-XPOS, vrel = vcount_in-YPOS, computed at 11 bits.
  - char_col = hrel/CHAR_W, char_row = vrel/CHAR_H, char_line = vrel mod CHAR_H, xoff = hrel mod CHAR_W.
  - Outside the box char_* are don't-care but must be stable; the block drives the truncated arithmetic.
- Delay line: a shift register of depth ROM_LAT carries {hcount, vcount, hsync, hblnk, vsync, vblnk, rgb_in, in_box, xoff, cursor_hit}. Its tail is aligned with char_pixels.
  - cursor_hit = in_box and char_col==cursor_col and char_row==cursor_row.
- Output register: one stage after the tail. Total latency of every output = ROM_LAT+1 cycles, identical for timing and rgb.
- Pixel select: bit = char_pixels[CHAR_W-1-xoff_d], using the delayed xoff only.
- Colour priority, evaluated on delayed values:
  - hblnk_d or vblnk_d -> 12'h000
  - else enable==0 or in_box_d==0 -> rgb_in_d
  - else: fg = FG_COLOR, bg = BG_COLOR; if cursor_en and cursor_hit_d and blink_phase==1, swap fg and bg.
  - bit==1 -> fg; bit==0 -> (transparent ? rgb_in_d : bg).
  - enable, transparent and cursor_en are sampled in the output stage (not delayed). Changes apply immediately.
- Blink:
  - vsync_prev <= vsync_in each cycle.
  - On a rising edge (vsync_in & ~vsync_prev): if frame_cnt==BLINK_FRAMES-1 then frame_cnt<=0 and blink_phase toggles; else frame_cnt+1.
  - frame_cnt width is clog2(BLINK_FRAMES)+1; it never exceeds BLINK_FRAMES-1.
  - blink_phase runs regardless of cursor_en.
- Boundary rules:
  - hcount_in wrapping from max back to 0 needs no special handling.
  - cursor_col >= COLS or cursor_row >= ROWS -> no cursor drawn.

Test Plan:
- Reset hold: rst=0 for 3 cycles with random inputs -> all outputs 0. Release, drive a counting hcount -> hcount_out equals hcount_in delayed by 3 cycles (defaults).
- Glyph alignment (defaults): bench ROM returns 8'b1000_0001 exactly 2 cycles after address. Pixel (490,600) -> rgb_out=12'h333 at cycle t+3; pixels 491..496 -> 12'heee; pixel 497 -> 12'h333. char_col=0, char_row=0, char_line=0 at t.
- Box edges: rgb_in=12'h0f0. Pixels (489,600), (530,600) and (490,616) -> 12'h0f0. Pixel (529,615) -> glyph/bg colour, with char_col=4 and char_line=15.
- Transparent/enable: transparent=1, glyph 8'h00 -> whole box shows rgb_in. enable=0 -> rgb_out==rgb_in delayed for all pixels. hblnk=1 -> 12'h000.
- Cursor blink: BLINK_FRAMES=2, cursor_col=2, cursor_en=1. Pulse vsync twice -> blink_phase=1 and cell 2 shows swapped colours (bit 1 -> 12'heee). Two more pulses -> normal colours. Cell 1 is unaffected throughout.
- Out-of-range cursor and frame counter: cursor_col=7 with COLS=5 -> no swap ever. vsync held high for 100 cycles counts as one edge only.

Source files
------------

// File: rtl/draw_text_box.sv
// -----------------------------------------------------------------------------
// draw_text_box
//
// Text-box overlay for the VGA timing stream. Draws a COLS x ROWS grid of
// CHAR_W x CHAR_H glyph cells whose top-left pixel is (XPOS, YPOS), on top of
// the incoming rgb stream. Sits after the board/mouse draw stages and is used
// for status lines and menus.
//
// The block computes the cell address (char_col, char_row, char_line)
// combinationally from the incoming position. An external char-code RAM / font
// ROM chain returns the glyph line ROM_LAT cycles later on char_pixels. The
// timing signals, the upstream colour and the per-pixel box information travel
// through a ROM_LAT-deep delay line, so the line's tail lines up with the glyph.
// One output register follows, so every output lags its input by ROM_LAT+1
// cycles.
//
// A blinking cursor cell swaps foreground and background while the blink phase
// is high. The phase toggles every BLINK_FRAMES rising edges of vsync_in.
//
// Ports
//   pclk                      pixel clock
//   rst                       synchronous reset, active low
//   hcount_in, vcount_in      incoming pixel position (11 bit)
//   hsync_in, hblnk_in,
//   vsync_in, vblnk_in        incoming timing
//   rgb_in                    upstream pixel colour (12 bit)
//   enable                    0 = block fully transparent (rgb passes through)
//   transparent               1 = glyph background pixels show rgb_in
//   cursor_en                 enables the blinking cursor cell
//   cursor_col, cursor_row    cursor cell; out-of-range values draw no cursor
//   char_pixels               glyph line from the font ROM, MSB = leftmost pixel
//   char_col, char_row        cell address, combinational from the inputs
//   char_line                 line within the cell, combinational
//   hcount_out .. vblnk_out   timing delayed by ROM_LAT+1 cycles
//   rgb_out                   composited colour, same latency
// -----------------------------------------------------------------------------
module draw_text_box #(
  parameter int          XPOS         = 490,
  parameter int          YPOS         = 600,
  parameter int          COLS         = 5,
  parameter int          ROWS         = 1,
  parameter int          CHAR_W       = 8,
  parameter int          CHAR_H       = 16,
  parameter int          ROM_LAT      = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'h333,
  parameter logic [11:0] BG_COLOR     = 12'heee,
  localparam int         COL_W        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         LINE_W       = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic              enable,
  input  logic              transparent,
  input  logic              cursor_en,
  input  logic [COL_W-1:0]  cursor_col,
  input  logic [ROW_W-1:0]  cursor_row,
  input  logic [CHAR_W-1:0] char_pixels,
  output logic [COL_W-1:0]  char_col,
  output logic [ROW_W-1:0]  char_row,
  output logic [LINE_W-1:0] char_line,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int XOFF_W  = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int X_SHIFT = $clog2(CHAR_W);
  localparam int Y_SHIFT = $clog2(CHAR_H);
  localparam int X_END   = XPOS + COLS * CHAR_W;
  localparam int Y_END   = YPOS + ROWS * CHAR_H;
  localparam int CNT_W   = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Everything the output stage needs about one pixel, captured at the input.
  typedef struct packed {
    logic [10:0]       hcount;
    logic [10:0]       vcount;
    logic              hsync;
    logic              hblnk;
    logic              vsync;
    logic              vblnk;
    logic [11:0]       rgb;
    logic              in_box;
    logic [XOFF_W-1:0] xoff;
    logic              cursor_hit;
  } pix_t;

  // Registered outputs.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } out_t;

  // ---------------------------------------------------------------------------
  // Box geometry and cell addressing (input side)
  // ---------------------------------------------------------------------------
  logic [10:0]       hrel;
  logic [10:0]       vrel;
  logic              in_box;
  logic [XOFF_W-1:0] xoff;
  logic              cursor_hit;
  pix_t              stage_in;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here: unconditionally); a path that skips a signal infers a latch.
  always_comb begin
    // Offsets wrap at 11 bits outside the box; char_* are then don't-care but
    // still a pure function of the inputs, so they stay stable.
    hrel   = hcount_in - 11'(XPOS);
    vrel   = vcount_in - 11'(YPOS);
    in_box = (int'(hcount_in) >= XPOS) && (int'(hcount_in) < X_END) &&
             (int'(vcount_in) >= YPOS) && (int'(vcount_in) < Y_END);
  end

  assign char_col  = COL_W'(hrel >> X_SHIFT);
  assign char_row  = ROW_W'(vrel >> Y_SHIFT);
  assign char_line = LINE_W'(vrel);
  assign xoff      = XOFF_W'(hrel);

  // A cursor outside the grid can never match an in-box cell address, so it
  // is simply never drawn.
  assign cursor_hit = in_box && (char_col == cursor_col) && (char_row == cursor_row);

  always_comb begin
    stage_in            = '0;
    stage_in.hcount     = hcount_in;
    stage_in.vcount     = vcount_in;
    stage_in.hsync      = hsync_in;
    stage_in.hblnk      = hblnk_in;
    stage_in.vsync      = vsync_in;
    stage_in.vblnk      = vblnk_in;
    stage_in.rgb        = rgb_in;
    stage_in.in_box     = in_box;
    stage_in.xoff       = xoff;
    stage_in.cursor_hit = cursor_hit;
  end

  // ---------------------------------------------------------------------------
  // Delay line: ROM_LAT stages, tail aligned with char_pixels
  // ---------------------------------------------------------------------------
  pix_t dly_d [ROM_LAT];
  pix_t dly_q [ROM_LAT];

  always_comb begin
    dly_d[0] = stage_in;
    for (int i = 1; i < ROM_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // NOTE: the delay line is cleared on reset on purpose, so that the first
  // ROM_LAT+1 cycles after reset emit zeros rather than stale pixels. Plain
  // storage arrays would normally be left without a reset.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  pix_t tail;
  assign tail = dly_q[ROM_LAT-1];

  // ---------------------------------------------------------------------------
  // Cursor blink: frame counter advanced on vsync rising edges
  // ---------------------------------------------------------------------------
  logic             vsync_prev_d, vsync_prev_q;
  logic [CNT_W-1:0] frame_cnt_d,  frame_cnt_q;
  logic             blink_phase_d, blink_phase_q;

  always_comb begin
    vsync_prev_d  = vsync_in;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    // Only the rising edge counts, so a long vsync pulse is one frame.
    if (vsync_in && !vsync_prev_q) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: pixel select and colour priority
  // ---------------------------------------------------------------------------
  // glyph_lr[i] is pixel i counted from the left edge of the cell.
  logic [CHAR_W-1:0] glyph_lr;
  logic              pix_bit;
  logic [11:0]       fg;
  logic [11:0]       bg;
  out_t              out_d, out_q;

  always_comb begin
    for (int i = 0; i < CHAR_W; i++) begin
      glyph_lr[i] = char_pixels[CHAR_W-1-i];
    end
  end

  assign pix_bit = glyph_lr[tail.xoff];

  always_comb begin
    fg = FG_COLOR;
    bg = BG_COLOR;
    if (cursor_en && tail.cursor_hit && blink_phase_q) begin
      fg = BG_COLOR;
      bg = FG_COLOR;
    end

    out_d.hcount = tail.hcount;
    out_d.vcount = tail.vcount;
    out_d.hsync  = tail.hsync;
    out_d.hblnk  = tail.hblnk;
    out_d.vsync  = tail.vsync;
    out_d.vblnk  = tail.vblnk;

    // enable/transparent/cursor_en act on the pixel now leaving the block,
    // not on the pixel that was entering when they changed.
    if (tail.hblnk || tail.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (!enable || !tail.in_box) begin
      out_d.rgb = tail.rgb;
    end else if (pix_bit) begin
      out_d.rgb = fg;
    end else if (transparent) begin
      out_d.rgb = tail.rgb;
    end else begin
      out_d.rgb = bg;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      out_q         <= '0;
      vsync_prev_q  <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule
